// File: rtl/fp_accum_requester_if.sv
// Bus bundle between the FP16 accumulate requester, its upstream element
// source, the 3-operand adder it drives and the downstream sum consumer.
//
// Handshake semantics:
//   in  : an element moves on a rising edge where in_valid && in_ready;
//         in_data/in_last are only meaningful while in_valid is high.
//   add : add_start rises with add_a/b/c already stable and stays high until
//         add_done is seen; add_z is valid while add_done=1; add_ack pulses
//         one cycle to release the result; no new add_start while add_done=1.
//   out : out_valid holds out_sum/out_count stable until out_ack is seen on a
//         rising edge with out_valid high.
interface fp_accum_requester_if #(
    parameter int CNT_W = 8
);
    logic             in_valid;
    logic [15:0]      in_data;
    logic             in_last;
    logic             in_ready;

    logic             add_start;
    logic [15:0]      add_a;
    logic [15:0]      add_b;
    logic [15:0]      add_c;
    logic [15:0]      add_z;
    logic             add_done;
    logic             add_ack;

    logic             out_valid;
    logic [15:0]      out_sum;
    logic [CNT_W-1:0] out_count;
    logic             out_ack;

    logic             err_timeout;

    modport master (
        input  in_valid, in_data, in_last,
        output in_ready,
        output add_start, add_a, add_b, add_c, add_ack,
        input  add_z, add_done,
        output out_valid, out_sum, out_count,
        input  out_ack,
        output err_timeout
    );

    modport slave (
        output in_valid, in_data, in_last,
        input  in_ready,
        input  add_start, add_a, add_b, add_c, add_ack,
        output add_z, add_done,
        input  out_valid, out_sum, out_count,
        output out_ack,
        input  err_timeout
    );
endinterface

// File: rtl/fp_accum_requester.sv
// Folds an FP16 element stream two-at-a-time into a running sum using an
// external 3-operand adder (acc + x0 + x1), then presents sum and count.
// No arithmetic is done here; the zero operand is exactly 16'h0000.
module fp_accum_requester #(
    parameter int CNT_W   = 8,
    parameter int TIMEOUT = 255
) (
    input  logic                         clk,
    input  logic                         reset,
    fp_accum_requester_if.master         bus,
    output logic [2:0]                   o_dbg_state
);

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_GET0 = 3'd1,
        S_GET1 = 3'd2,
        S_REQ  = 3'd3,
        S_ACK  = 3'd4,
        S_CLR  = 3'd5,
        S_OUT  = 3'd6,
        S_ERR  = 3'd7
    } state_t;

    localparam int               WD_W    = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;
    localparam bit               WD_EN   = (TIMEOUT > 0);
    localparam logic [WD_W-1:0]  WD_LAST = (TIMEOUT > 0) ? WD_W'(TIMEOUT - 1) : '0;
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    state_t           r_state;
    state_t           w_next;
    logic [15:0]      r_acc;
    logic [15:0]      r_x0;
    logic             r_last;
    logic [CNT_W-1:0] r_count;
    logic [15:0]      r_add_a;
    logic [15:0]      r_add_b;
    logic [15:0]      r_add_c;
    logic [15:0]      r_out_sum;
    logic [CNT_W-1:0] r_out_count;
    logic             r_err;
    logic [WD_W-1:0]  r_wd;

    logic             w_accept;
    logic [CNT_W-1:0] w_cnt_inc;
    logic             w_last_in;
    logic             w_wd_hit;

    assign w_accept  = bus.in_valid && ((r_state == S_GET0) || (r_state == S_GET1));
    assign w_cnt_inc = r_count + 1'b1;
    // An element that fills the counter closes the stream as if in_last was set.
    assign w_last_in = bus.in_last || (w_cnt_inc == CNT_MAX);
    assign w_wd_hit  = WD_EN && (r_wd == WD_LAST);

    // Control outputs decode directly from the registered state.
    assign bus.in_ready    = (r_state == S_GET0) || (r_state == S_GET1);
    assign bus.add_start   = (r_state == S_REQ);
    assign bus.add_ack     = (r_state == S_ACK);
    assign bus.out_valid   = (r_state == S_OUT);
    assign bus.add_a       = r_add_a;
    assign bus.add_b       = r_add_b;
    assign bus.add_c       = r_add_c;
    assign bus.out_sum     = r_out_sum;
    assign bus.out_count   = r_out_count;
    assign bus.err_timeout = r_err;
    assign o_dbg_state     = r_state;

    // State register.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Next-state logic; done wins over the watchdog on the same cycle.
    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE: w_next = S_GET0;
            S_GET0: if (w_accept) w_next = w_last_in ? S_REQ : S_GET1;
            S_GET1: if (w_accept) w_next = S_REQ;
            S_REQ: begin
                if (bus.add_done)  w_next = S_ACK;
                else if (w_wd_hit) w_next = S_ERR;
            end
            S_ACK:  w_next = S_CLR;
            S_CLR: begin
                if (!bus.add_done) w_next = r_last ? S_OUT : S_GET0;
                else if (w_wd_hit) w_next = S_ERR;
            end
            S_OUT:  if (bus.out_ack) w_next = S_IDLE;
            S_ERR:  w_next = S_ERR;
            default: w_next = S_IDLE;
        endcase
    end

    // Datapath: element capture, operand staging, accumulator and result.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_acc       <= 16'h0000;
            r_x0        <= 16'h0000;
            r_last      <= 1'b0;
            r_count     <= '0;
            r_add_a     <= 16'h0000;
            r_add_b     <= 16'h0000;
            r_add_c     <= 16'h0000;
            r_out_sum   <= 16'h0000;
            r_out_count <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    r_acc   <= 16'h0000;
                    r_count <= '0;
                    r_last  <= 1'b0;
                end
                S_GET0: begin
                    if (w_accept) begin
                        r_x0    <= bus.in_data;
                        r_count <= w_cnt_inc;
                        if (w_last_in) begin
                            // Odd tail: pair the element with an exact zero.
                            r_last  <= 1'b1;
                            r_add_a <= r_acc;
                            r_add_b <= bus.in_data;
                            r_add_c <= 16'h0000;
                        end
                    end
                end
                S_GET1: begin
                    if (w_accept) begin
                        r_count <= w_cnt_inc;
                        r_last  <= w_last_in;
                        r_add_a <= r_acc;
                        r_add_b <= r_x0;
                        r_add_c <= bus.in_data;
                    end
                end
                S_REQ: begin
                    if (bus.add_done) r_acc <= bus.add_z;
                end
                S_CLR: begin
                    if (!bus.add_done && r_last) begin
                        r_out_sum   <= r_acc;
                        r_out_count <= r_count;
                    end
                end
                default: ;
            endcase
        end
    end

    // Watchdog: restarts on every state change, counts while waiting on the adder.
    always_ff @(posedge clk) begin
        if (reset || (w_next != r_state)) begin
            r_wd <= '0;
        end else if ((r_state == S_REQ) || (r_state == S_CLR)) begin
            r_wd <= r_wd + 1'b1;
        end
    end

    // Sticky timeout flag, cleared only by reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_err <= 1'b0;
        end else if (w_next == S_ERR) begin
            r_err <= 1'b1;
        end
    end

endmodule
